sipo_shl_rx: RTL and testbench
==============================

SIPO_SHL_RX -- requirements
Module: sipo_shl_rx

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 din  input  1  serial data bit, MSB first.
REQ-005 din_vld  input  1  qualifies din for one clk cycle.
REQ-006 start  input  1  one-cycle frame-start pulse.
REQ-007 dout  output  WIDTH  assembled parallel word, registered.
REQ-008 dout_vld  output  1  dout holds an unconsumed word.
REQ-009 dout_rdy  input  1  consumer accepts dout when high together with dout_vld.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 overrun  output  1  sticky error flag.
REQ-012 parity_err  output  1  parity result for the word in dout, valid while dout_vld is high.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT, PARITY (only with SIPO_PARITY_EN) and HOLD.
REQ-014 IDLE: din_vld ignored; start -> SHIFT, bit counter cleared to 0.
REQ-015 SHIFT: each din_vld shifts the internal register left, din entering bit 0, and increments the counter.
REQ-016 SHIFT: cycles without din_vld hold the shift register and the counter.
REQ-017 SHIFT, din_vld on bit WIDTH-1: if the output slot is free (dout_vld=0, or dout_vld=1 and dout_rdy=1), load dout and go IDLE; otherwise go HOLD.
REQ-018 Latency: dout_vld SHALL rise in the clk cycle after the strobe of the last bit (the parity bit when SIPO_PARITY_EN is defined).
REQ-019 HOLD: keep the completed word; transfer it to dout and go IDLE in the cycle in which dout_rdy=1.
REQ-020 HOLD: any din_vld sets overrun to 1 and that bit is discarded; start is ignored.
REQ-021 overrun SHALL stay at 1 until reset.
REQ-022 start in SHIFT or PARITY SHALL abort the frame, clear the counter and remain in or return to SHIFT; the partial word is discarded.
REQ-023 start together with din_vld in the same cycle: start wins and din is not sampled.
REQ-024 dout and parity_err SHALL stay stable while dout_vld=1 and dout_rdy=0.
REQ-025 A handshake (dout_vld=1 and dout_rdy=1) with no new word loading in that cycle SHALL clear dout_vld in the next cycle.
REQ-026 A handshake in the same cycle as a new word loads SHALL keep dout_vld at 1 and present the new word.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL never exceed WIDTH.

Reset
REQ-028 With rst=0, asynchronously: state=IDLE, counter=0, shift register=0, dout=0, dout_vld=0, busy=0, overrun=0, parity_err=0.
REQ-029 Reset during SHIFT, PARITY or HOLD SHALL discard all partial or pending data; the first frame after reset release needs a new start.

Configuration
REQ-030 Macro SIPO_PARITY_EN: when defined, the block SHALL expect one extra even-parity bit after the WIDTH data bits.
REQ-031 With SIPO_PARITY_EN defined: after bit WIDTH-1, SHIFT -> PARITY; the next din_vld is the parity bit, then REQ-017 applies.
REQ-032 With SIPO_PARITY_EN defined: parity_err=1 when the XOR of the data bits and the parity bit is 1.
REQ-033 Without SIPO_PARITY_EN: the PARITY state is absent and parity_err is tied to 0.

Verification (WIDTH=8)
REQ-034 start, then bits 1,0,1,0,0,1,0,1 on consecutive cycles -> dout=8'hA5, dout_vld=1 one cycle after the last bit, busy=0 at the same time.
REQ-035 Bits of 8'h3C with gaps of 2 idle cycles between strobes -> dout=8'h3C; the shift register and counter are unchanged during the gaps.
REQ-036 Word 8'hA5 held with dout_rdy=0, second frame 8'hFF completed, then 2 more din_vld -> state HOLD, overrun=1, dout stays 8'hA5; dout_rdy=1 -> dout=8'hFF next cycle.
REQ-037 start after 4 bits, then a full frame of 8'h81 -> dout=8'h81; the aborted bits do not appear in dout.
REQ-038 rst=0 asserted mid-frame after 5 bits -> all outputs 0 immediately; after release, a new frame of 8'h5A -> dout=8'h5A.
REQ-039 With SIPO_PARITY_EN defined: 8'hA5 followed by parity 0 -> parity_err=0; 8'hA5 followed by parity 1 -> parity_err=1; dout_vld rises one cycle after the parity bit in both cases.

Source files
------------

// File: rtl/sipo_shl_rx.sv
// Serial-in parallel-out receiver: MSB-first frames assembled into a registered word with a valid/ready output.
// Optional macro SIPO_PARITY_EN adds a trailing even-parity bit per frame and drives parity_err.
module sipo_shl_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SIPO_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd3} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word_nxt;
  logic [CW-1:0]    cnt;
  logic             slot_free;
  logic             last_bit;

  assign word_nxt  = {shreg[WIDTH-2:0], din};
  assign slot_free = !dout_vld || dout_rdy;
  assign last_bit  = (cnt == CW'(WIDTH - 1));

`ifdef SIPO_PARITY_EN
  logic perr_hold;
  logic perr_nxt;

  assign perr_nxt = (^shreg) ^ din;
`else
  assign parity_err = 1'b0;
`endif

  // A completed word sits in shreg while HOLD waits for the output slot to drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shreg    <= '0;
      cnt      <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
`ifdef SIPO_PARITY_EN
      parity_err <= 1'b0;
      perr_hold  <= 1'b0;
`endif
    end else begin
      if (dout_vld && dout_rdy)
        dout_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            busy  <= 1'b1;
            cnt   <= '0;
            shreg <= '0;
          end
        end

        SHIFT: begin
          if (start) begin
            cnt   <= '0;
            shreg <= '0;
          end else if (din_vld) begin
            shreg <= word_nxt;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
`ifdef SIPO_PARITY_EN
              state <= PARITY;
`else
              if (slot_free) begin
                dout     <= word_nxt;
                dout_vld <= 1'b1;
                state    <= IDLE;
                busy     <= 1'b0;
              end else begin
                state <= HOLD;
              end
`endif
            end
          end
        end

`ifdef SIPO_PARITY_EN
        PARITY: begin
          if (start) begin
            state <= SHIFT;
            cnt   <= '0;
            shreg <= '0;
          end else if (din_vld) begin
            if (slot_free) begin
              dout       <= shreg;
              parity_err <= perr_nxt;
              dout_vld   <= 1'b1;
              state      <= IDLE;
              busy       <= 1'b0;
            end else begin
              perr_hold <= perr_nxt;
              state     <= HOLD;
            end
          end
        end
`endif

        HOLD: begin
          if (din_vld)
            overrun <= 1'b1;
          if (dout_rdy) begin
            dout     <= shreg;
            dout_vld <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= perr_hold;
`endif
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_shl_rx.sv
// Self-checking bench for sipo_shl_rx: vector table, directed corner sequences, then random traffic vs a frame-level model.
// Follows SIPO_PARITY_EN the same way as the design.
module tb_sipo_shl_rx;

  localparam int WIDTH = 8;
`ifdef SIPO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             din;
  logic             din_vld;
  logic             start;
  logic [WIDTH-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;
  logic             busy;
  logic             overrun;
  logic             parity_err;

  int errors = 0;
  int checks = 0;

  sipo_shl_rx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_vld    (din_vld),
    .start      (start),
    .dout       (dout),
    .dout_vld   (dout_vld),
    .dout_rdy   (dout_rdy),
    .busy       (busy),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             s;
    logic             v;
    logic             d;
    logic             r;
    logic [WIDTH-1:0] exp_dout;
    logic             exp_vld;
    logic             exp_busy;
    logic             exp_ovr;
    logic             exp_perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, v, d, r, input logic [WIDTH-1:0] ed,
                              input logic ev, eb, eo, ep);
    vec_t t;
    t.s = s; t.v = v; t.d = d; t.r = r;
    t.exp_dout = ed; t.exp_vld = ev; t.exp_busy = eb; t.exp_ovr = eo; t.exp_perr = ep;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] ed,
                             input logic ev, eb, eo, ep);
    checks++;
    if ({dout, dout_vld, busy, overrun, parity_err} !== {ed, ev, eb, eo, ep}) begin
      errors++;
      $display("[TB] FAIL %s: got dout=%h vld=%b busy=%b ovr=%b perr=%b, want dout=%h vld=%b busy=%b ovr=%b perr=%b",
               name, dout, dout_vld, busy, overrun, parity_err, ed, ev, eb, eo, ep);
    end
  endtask

  // Inputs change just after the falling edge; outputs are checked on the next falling edge.
  task automatic applyStimulus(input logic s, v, d, r);
    start = s; din_vld = v; din = d; dout_rdy = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendFrame(input logic [WIDTH-1:0] w, input logic r, input logic pbit);
    applyStimulus(1'b1, 1'b0, 1'b0, r);
    for (int i = WIDTH - 1; i >= 0; i--)
      applyStimulus(1'b0, 1'b1, w[i], r);
    if (PAR != 0)
      applyStimulus(1'b0, 1'b1, pbit, r);
  endtask

  // Frame-level reference: a bit queue per frame, one pending word, one output slot.
  logic             m_in_frame;
  logic             m_bits[$];
  logic             m_pend_valid;
  logic [WIDTH-1:0] m_pend_word;
  logic             m_pend_perr;
  logic             m_out_valid;
  logic [WIDTH-1:0] m_out_word;
  logic             m_out_perr;
  logic             m_ovr;

  task automatic modelReset();
    m_in_frame = 0; m_bits.delete(); m_pend_valid = 0; m_pend_word = '0; m_pend_perr = 0;
    m_out_valid = 0; m_out_word = '0; m_out_perr = 0; m_ovr = 0;
  endtask

  task automatic modelStep(input logic s, v, d, r);
    logic             loaded;
    logic             hs;
    logic [WIDTH-1:0] w;
    logic             p;
    loaded = 0;
    hs = m_out_valid && r;
    if (m_pend_valid) begin
      if (v) m_ovr = 1;
      if (r) begin
        m_out_word = m_pend_word; m_out_perr = m_pend_perr;
        m_out_valid = 1; m_pend_valid = 0; loaded = 1;
      end
    end else if (m_in_frame) begin
      if (s) begin
        m_bits.delete();
      end else if (v) begin
        m_bits.push_back(d);
        if (m_bits.size() == WIDTH + PAR) begin
          w = '0; p = 0;
          for (int k = 0; k < WIDTH; k++) w = {w[WIDTH-2:0], m_bits[k]};
          for (int k = 0; k < WIDTH + PAR; k++) p = p ^ m_bits[k];
          if (PAR == 0) p = 0;
          m_bits.delete();
          m_in_frame = 0;
          if (!m_out_valid || r) begin
            m_out_word = w; m_out_perr = p; m_out_valid = 1; loaded = 1;
          end else begin
            m_pend_word = w; m_pend_perr = p; m_pend_valid = 1;
          end
        end
      end
    end else if (s) begin
      m_in_frame = 1;
      m_bits.delete();
    end
    if (hs && !loaded) m_out_valid = 0;
  endtask

  initial begin
    logic [WIDTH-1:0] a5;
    logic [WIDTH-1:0] f0;
    logic             last;
    logic             s, v, d, r;

    rst = 1'b0; start = 1'b0; din = 1'b0; din_vld = 1'b0; dout_rdy = 1'b0;
    #12;
    checkOutput("reset", '0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // A5 frame, handshake, idle din_vld ignored, then start+din_vld abort inside a 0F frame
    a5 = 8'hA5;
    f0 = 8'h0F;
    vecs.push_back(mk(1, 0, 0, 0, '0, 0, 1, 0, 0));
    for (int i = WIDTH - 1; i >= 0; i--) begin
      last = (i == 0) && (PAR == 0);
      vecs.push_back(mk(0, 1, a5[i], 0, last ? a5 : '0, last, !last, 0, 0));
    end
    if (PAR != 0) vecs.push_back(mk(0, 1, 0, 0, a5, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, a5, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, a5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, a5, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 1, 1, 0, a5, 0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, a5, 0, 1, 0, 0));
    for (int i = WIDTH - 1; i >= 0; i--) begin
      last = (i == 0) && (PAR == 0);
      vecs.push_back(mk(0, 1, f0[i], 0, last ? f0 : a5, last, !last, 0, 0));
    end
    if (PAR != 0) vecs.push_back(mk(0, 1, 0, 0, f0, 1, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s, vecs[i].v, vecs[i].d, vecs[i].r);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_dout, vecs[i].exp_vld,
                  vecs[i].exp_busy, vecs[i].exp_ovr, vecs[i].exp_perr);
    end
    applyStimulus(0, 0, 0, 1);
    checkOutput("consume0F", 8'h0F, 0, 0, 0, 0);

    // 3C with two idle cycles between strobes
    applyStimulus(1, 0, 0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(0, 1, f0[i] ^ 1'b0, 0);
      if (i > 0) begin end
    end
    applyStimulus(0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checkOutput("reset2", '0, 0, 0, 0, 0);
    a5 = 8'h3C;
    applyStimulus(1, 0, 0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      applyStimulus(0, 1, a5[i], 0);
      if (i > 0 || PAR != 0) begin
        repeat (2) begin
          applyStimulus(0, 0, 0, 0);
          checkOutput("gap", '0, 0, 1, 0, 0);
        end
      end
    end
    if (PAR != 0) applyStimulus(0, 1, ^a5, 0);
    checkOutput("gapword", 8'h3C, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("consume3C", 8'h3C, 0, 0, 0, 0);

    // Abort after four bits, then a full 81 frame
    applyStimulus(1, 0, 0, 0);
    repeat (4) applyStimulus(0, 1, 1, 0);
    checkOutput("partial", 8'h3C, 0, 1, 0, 0);
    sendFrame(8'h81, 0, ^8'h81);
    checkOutput("abort81", 8'h81, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

    // Output slot blocked: second word waits, extra strobes raise overrun
    sendFrame(8'hA5, 0, ^8'hA5);
    checkOutput("firstA5", 8'hA5, 1, 0, 0, 0);
    sendFrame(8'hFF, 0, ^8'hFF);
    checkOutput("holdFF", 8'hA5, 1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("overrun", 8'hA5, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("holdstart", 8'hA5, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("releaseFF", 8'hFF, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("drainFF", 8'hFF, 0, 0, 1, 0);

    // Asynchronous reset mid-frame, then start is required again
    applyStimulus(1, 0, 0, 0);
    repeat (5) applyStimulus(0, 1, 1, 0);
    #2 rst = 1'b0;
    #1 checkOutput("asyncrst", '0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 1, 1, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("nostart", '0, 0, 0, 0, 0);
    sendFrame(8'h5A, 0, ^8'h5A);
    checkOutput("after5A", 8'h5A, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);

`ifdef SIPO_PARITY_EN
    a5 = 8'hA5;
    applyStimulus(1, 0, 0, 0);
    for (int i = WIDTH - 1; i >= 0; i--) applyStimulus(0, 1, a5[i], 0);
    checkOutput("predpar", 8'h5A, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0);
    checkOutput("parbad", 8'hA5, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 1);
    sendFrame(8'hA5, 0, 1'b0);
    checkOutput("pargood", 8'hA5, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
`endif

    // Random traffic against the frame-level model
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 19) == 0);
      v = 1'($urandom_range(0, 1));
      d = 1'($urandom);
      r = ($urandom_range(0, 3) == 0);
      applyStimulus(s, v, d, r);
      modelStep(s, v, d, r);
      checkOutput("rand", m_out_word, m_out_valid, m_in_frame || m_pend_valid, m_ovr, m_out_perr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
